// File: rtl/stack_pkg.sv
// Shared definitions for the Forth CPU hardware stack: the 2-bit operation
// encoding and the TOS source select used between controller and datapath.
package stack_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_NOP     = 2'b00;
  localparam op_t OP_PUSH    = 2'b01;
  localparam op_t OP_POP     = 2'b10;
  localparam op_t OP_REPLACE = 2'b11;

  // Where the TOS register takes its next value from.
  typedef enum logic [1:0] {
    TOS_HOLD     = 2'b00,
    TOS_LOAD_D   = 2'b01,
    TOS_LOAD_NOS = 2'b10
  } tos_sel_e;

endpackage

// File: rtl/stack_ctl.sv
// Stack controller: combinational next-state for the RAM pointer, element
// count and sticky error flags, plus the RAM write enable and the TOS source.
// Plain arithmetic on sp/depth; no storage lives here.
module stack_ctl
  import stack_pkg::*;
#(
  parameter int AW   = 3,
  parameter bit WRAP = 1'b1
) (
  input  op_t            op_i,
  input  logic [AW-1:0]  sp_i,
  input  logic [AW:0]    depth_i,
  input  logic           ovf_i,
  input  logic           unf_i,
  input  logic           clr_err_i,
  output logic [AW-1:0]  sp_d_o,
  output logic [AW:0]    depth_d_o,
  output logic           ovf_d_o,
  output logic           unf_d_o,
  output logic           mem_we_o,
  output tos_sel_e       tos_sel_o,
  output logic           empty_o,
  output logic           full_o
);

  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  assign empty_o = (depth_i == '0);
  assign full_o  = (depth_i == DEPTH_C);

  // Decode the op against the current occupancy into next-state values.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would infer a latch.
    sp_d_o    = sp_i;
    depth_d_o = depth_i;
    mem_we_o  = 1'b0;
    tos_sel_o = TOS_HOLD;
    // clr_err clears first; a new error below sets the flag again, so a
    // coincident error event wins over the clear.
    ovf_d_o   = ovf_i & ~clr_err_i;
    unf_d_o   = unf_i & ~clr_err_i;

    case (op_i)
      OP_PUSH, OP_REPLACE: begin
        if (op_i == OP_REPLACE && !empty_o) begin
          tos_sel_o = TOS_LOAD_D;
        end else if (full_o) begin
          // Push onto a full stack (REPLACE cannot get here: it only
          // pushes when empty).
          ovf_d_o = 1'b1;
          if (WRAP) begin
            // Circular: spill TOS over the oldest slot, count stays DEPTH.
            mem_we_o  = 1'b1;
            sp_d_o    = sp_i + AW'(1);
            tos_sel_o = TOS_LOAD_D;
          end
        end else begin
          // Ordinary push, also REPLACE on an empty stack.
          mem_we_o  = 1'b1;
          sp_d_o    = sp_i + AW'(1);
          depth_d_o = depth_i + (AW+1)'(1);
          tos_sel_o = TOS_LOAD_D;
        end
      end
      OP_POP: begin
        if (empty_o) begin
          unf_d_o = 1'b1;
        end else begin
          sp_d_o    = sp_i - AW'(1);
          depth_d_o = depth_i - (AW+1)'(1);
          tos_sel_o = TOS_LOAD_NOS;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/param_stack.sv
// Parameterised hardware stack for the Forth CPU data and return stacks.
// TOS is a register; deeper entries sit in an asynchronously read RAM
// addressed by sp (the next-on-stack slot). Optional build macro
// STACK_NOS_OUT_EN exposes the NOS word as an output port.
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AW    = 3,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wait_state,
  input  op_t              op,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [AW:0]      depth,
  output logic             empty,
  output logic             full,
`ifdef STACK_NOS_OUT_EN
  output logic [WIDTH-1:0] nos,
`endif
  output logic             ovf,
  output logic             unf
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] tos_q;
  logic [AW-1:0]    sp_q, sp_d;
  logic [AW:0]      depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             mem_we;
  tos_sel_e         tos_sel;
  logic [WIDTH-1:0] nos_val;

  logic [WIDTH-1:0] mem [DEPTH];

  assign nos_val = mem[sp_q];

  stack_ctl #(
    .AW   (AW),
    .WRAP (WRAP)
  ) u_ctl (
    .op_i      (op),
    .sp_i      (sp_q),
    .depth_i   (depth_q),
    .ovf_i     (ovf_q),
    .unf_i     (unf_q),
    .clr_err_i (clr_err),
    .sp_d_o    (sp_d),
    .depth_d_o (depth_d),
    .ovf_d_o   (ovf_d),
    .unf_d_o   (unf_d),
    .mem_we_o  (mem_we),
    .tos_sel_o (tos_sel),
    .empty_o   (empty),
    .full_o    (full)
  );

  // Control state and TOS: reset wins over stall, stall freezes everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      tos_q   <= '0;
      sp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (!wait_state) begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      case (tos_sel)
        TOS_LOAD_D:   tos_q <= d;
        TOS_LOAD_NOS: tos_q <= nos_val;
        default:      tos_q <= tos_q;
      endcase
    end
  end

  // Spill the old TOS into the slot that becomes the new NOS.
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset; depth tracks which slots are valid, and
    // keeping reset off the array lets it map onto distributed/block RAM.
    if (!reset && !wait_state && mem_we) begin
      mem[sp_d] <= tos_q;
    end
  end

  assign q     = tos_q;
  assign depth = depth_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

`ifdef STACK_NOS_OUT_EN
  assign nos = nos_val;
`endif

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack: one circular (WRAP=1) and one
// saturating (WRAP=0) instance share stimulus. Directed vector table,
// hand-written capacity/stall sequences, then random ops against a
// shift-array reference model.
module tb_param_stack;
  import stack_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        wait_state = 1'b0;
  logic        clr_err = 1'b0;
  op_t         op = OP_NOP;
  logic [15:0] d = '0;

  // Index 0 = saturating instance, index 1 = circular instance.
  logic [15:0] q_m     [2];
  logic [3:0]  depth_m [2];
  logic        empty_m [2];
  logic        full_m  [2];
  logic        ovf_m   [2];
  logic        unf_m   [2];
`ifdef STACK_NOS_OUT_EN
  logic [15:0] nos_m   [2];
`endif

  param_stack #(.WIDTH(16), .AW(3), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .wait_state(wait_state), .op(op), .d(d),
    .clr_err(clr_err), .q(q_m[0]), .depth(depth_m[0]), .empty(empty_m[0]),
    .full(full_m[0]),
`ifdef STACK_NOS_OUT_EN
    .nos(nos_m[0]),
`endif
    .ovf(ovf_m[0]), .unf(unf_m[0])
  );

  param_stack #(.WIDTH(16), .AW(3), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .wait_state(wait_state), .op(op), .d(d),
    .clr_err(clr_err), .q(q_m[1]), .depth(depth_m[1]), .empty(empty_m[1]),
    .full(full_m[1]),
`ifdef STACK_NOS_OUT_EN
    .nos(nos_m[1]),
`endif
    .ovf(ovf_m[1]), .unf(unf_m[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference model: arr[m][0] is the bottom, arr[m][cnt-1] the top.
  int          cnt [2];
  logic [15:0] arr [2][8];
  logic        mo  [2];
  logic        mu  [2];

  typedef struct {
    op_t         op;
    logic [15:0] d;
    logic        clr;
    logic [15:0] exp_q;
    logic [3:0]  exp_depth;
    logic        exp_unf;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int m, input op_t o, input logic [15:0] dv,
                            input logic c, input logic w, input logic r);
    logic new_o, new_u;
    new_o = 1'b0;
    new_u = 1'b0;
    if (r) begin
      cnt[m] = 0; mo[m] = 1'b0; mu[m] = 1'b0;
    end else if (!w) begin
      if (o == OP_PUSH || (o == OP_REPLACE && cnt[m] == 0)) begin
        if (cnt[m] < 8) begin
          arr[m][cnt[m]] = dv;
          cnt[m]++;
        end else begin
          new_o = 1'b1;
          if (m == 1) begin
            for (int k = 0; k < 7; k++) arr[m][k] = arr[m][k+1];
            arr[m][7] = dv;
          end
        end
      end else if (o == OP_POP) begin
        if (cnt[m] == 0) new_u = 1'b1;
        else cnt[m]--;
      end else if (o == OP_REPLACE) begin
        arr[m][cnt[m]-1] = dv;
      end
      if (c) begin mo[m] = 1'b0; mu[m] = 1'b0; end
      if (new_o) mo[m] = 1'b1;
      if (new_u) mu[m] = 1'b1;
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input op_t o, input logic [15:0] dv, input logic c,
                      input logic w, input logic r);
    op = o; d = dv; clr_err = c; wait_state = w; reset = r;
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) model_step(m, o, dv, c, w, r);
  endtask

  task automatic check_model(input string tag);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s[%0d].depth", tag, m), 32'(depth_m[m]), 32'(cnt[m]));
      check($sformatf("%s[%0d].empty", tag, m), 32'(empty_m[m]), 32'(cnt[m] == 0));
      check($sformatf("%s[%0d].full", tag, m), 32'(full_m[m]), 32'(cnt[m] == 8));
      check($sformatf("%s[%0d].ovf", tag, m), 32'(ovf_m[m]), 32'(mo[m]));
      check($sformatf("%s[%0d].unf", tag, m), 32'(unf_m[m]), 32'(mu[m]));
      if (cnt[m] > 0)
        check($sformatf("%s[%0d].q", tag, m), 32'(q_m[m]), 32'(arr[m][cnt[m]-1]));
    end
  endtask

  initial begin
    // Directed vectors common to both modes (never reaches capacity).
    vt[0]  = '{OP_PUSH,    16'h0011, 1'b0, 16'h0011, 4'd1, 1'b0};
    vt[1]  = '{OP_PUSH,    16'h0022, 1'b0, 16'h0022, 4'd2, 1'b0};
    vt[2]  = '{OP_PUSH,    16'h0033, 1'b0, 16'h0033, 4'd3, 1'b0};
    vt[3]  = '{OP_POP,     16'h0000, 1'b0, 16'h0022, 4'd2, 1'b0};
    vt[4]  = '{OP_POP,     16'h0000, 1'b0, 16'h0011, 4'd1, 1'b0};
    vt[5]  = '{OP_POP,     16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0};
    vt[6]  = '{OP_POP,     16'h0000, 1'b0, 16'h0000, 4'd0, 1'b1};
    vt[7]  = '{OP_NOP,     16'h0000, 1'b1, 16'h0000, 4'd0, 1'b0};
    vt[8]  = '{OP_POP,     16'h0000, 1'b1, 16'h0000, 4'd0, 1'b1};
    vt[9]  = '{OP_NOP,     16'h0000, 1'b1, 16'h0000, 4'd0, 1'b0};
    vt[10] = '{OP_REPLACE, 16'h00AA, 1'b0, 16'h00AA, 4'd1, 1'b0};
    vt[11] = '{OP_PUSH,    16'h00BB, 1'b0, 16'h00BB, 4'd2, 1'b0};
    vt[12] = '{OP_REPLACE, 16'h00CC, 1'b0, 16'h00CC, 4'd2, 1'b0};
    vt[13] = '{OP_POP,     16'h0000, 1'b0, 16'h00AA, 4'd1, 1'b0};

    // Reset state.
    step(OP_NOP, 16'h0, 1'b0, 1'b0, 1'b1);
    step(OP_NOP, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rst[%0d].q", m), 32'(q_m[m]), 32'h0);
      check($sformatf("rst[%0d].depth", m), 32'(depth_m[m]), 32'd0);
      check($sformatf("rst[%0d].empty", m), 32'(empty_m[m]), 32'd1);
      check($sformatf("rst[%0d].full", m), 32'(full_m[m]), 32'd0);
      check($sformatf("rst[%0d].ovf", m), 32'(ovf_m[m]), 32'd0);
      check($sformatf("rst[%0d].unf", m), 32'(unf_m[m]), 32'd0);
    end

    for (int i = 0; i < 14; i++) begin
      step(vt[i].op, vt[i].d, vt[i].clr, 1'b0, 1'b0);
      for (int m = 0; m < 2; m++) begin
        check($sformatf("vec%0d[%0d].depth", i, m), 32'(depth_m[m]), 32'(vt[i].exp_depth));
        check($sformatf("vec%0d[%0d].unf", i, m), 32'(unf_m[m]), 32'(vt[i].exp_unf));
        check($sformatf("vec%0d[%0d].ovf", i, m), 32'(ovf_m[m]), 32'd0);
        if (vt[i].exp_depth != 0)
          check($sformatf("vec%0d[%0d].q", i, m), 32'(q_m[m]), 32'(vt[i].exp_q));
      end
    end

    // Capacity: push 1..9, then pop 7.
    step(OP_NOP, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) step(OP_PUSH, 16'(i), 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("cap[%0d].depth", m), 32'(depth_m[m]), 32'd8);
      check($sformatf("cap[%0d].full", m), 32'(full_m[m]), 32'd1);
      check($sformatf("cap[%0d].ovf", m), 32'(ovf_m[m]), 32'd1);
    end
    check("cap_wrap.q", 32'(q_m[1]), 32'd9);
    check("cap_sat.q", 32'(q_m[0]), 32'd8);
    for (int k = 1; k <= 7; k++) begin
      step(OP_POP, 16'h0, 1'b0, 1'b0, 1'b0);
      check($sformatf("pop%0d_wrap.q", k), 32'(q_m[1]), 32'(9 - k));
      check($sformatf("pop%0d_sat.q", k), 32'(q_m[0]), 32'(8 - k));
    end
    for (int m = 0; m < 2; m++)
      check($sformatf("pop7[%0d].depth", m), 32'(depth_m[m]), 32'd1);
    step(OP_NOP, 16'h0, 1'b1, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++)
      check($sformatf("clr_ovf[%0d]", m), 32'(ovf_m[m]), 32'd0);

    // Overflow coinciding with clr_err: the new event wins.
    step(OP_NOP, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) step(OP_PUSH, 16'(i), 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++)
      check($sformatf("full_no_ovf[%0d]", m), 32'(ovf_m[m]), 32'd0);
    step(OP_PUSH, 16'h0009, 1'b1, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++)
      check($sformatf("ovf_vs_clr[%0d]", m), 32'(ovf_m[m]), 32'd1);

    // Stall freezes everything, including clr_err.
    step(OP_NOP, 16'h0, 1'b0, 1'b0, 1'b1);
    step(OP_POP, 16'h0, 1'b0, 1'b0, 1'b0);
    step(OP_PUSH, 16'h0100, 1'b0, 1'b0, 1'b0);
    step(OP_PUSH, 16'h0200, 1'b0, 1'b0, 1'b0);
    step(OP_PUSH, 16'h0300, 1'b0, 1'b1, 1'b0);
    step(OP_POP, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(OP_NOP, 16'h0000, 1'b1, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("wait[%0d].q", m), 32'(q_m[m]), 32'h0200);
      check($sformatf("wait[%0d].depth", m), 32'(depth_m[m]), 32'd2);
      check($sformatf("wait[%0d].unf", m), 32'(unf_m[m]), 32'd1);
`ifdef STACK_NOS_OUT_EN
      check($sformatf("nos[%0d]", m), 32'(nos_m[m]), 32'h0100);
`endif
    end
    step(OP_PUSH, 16'h0400, 1'b0, 1'b1, 1'b1);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rst_wait[%0d].depth", m), 32'(depth_m[m]), 32'd0);
      check($sformatf("rst_wait[%0d].q", m), 32'(q_m[m]), 32'h0);
      check($sformatf("rst_wait[%0d].unf", m), 32'(unf_m[m]), 32'd0);
    end

    // Random ops against the reference model.
    for (int i = 0; i < 800; i++) begin
      step(op_t'($urandom_range(3)), 16'($urandom), ($urandom_range(7) == 0),
           ($urandom_range(7) == 0), ($urandom_range(99) == 0));
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
